// File: rtl/magnitude_comparator_seq.sv
// rtl/magnitude_comparator_seq.sv - digit-serial magnitude comparator, MSB digit first with early exit
// Signed operands are biased by flipping the MSB at capture, so the serial compare stays unsigned.
module magnitude_comparator_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               is_signed,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               eq,
  output logic                               gt,
  output logic                               lt,
  output logic [$clog2(WIDTH/DIGIT):0]       steps
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW   = $clog2(NDIG) + 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0]    idx;
  logic [SW-1:0]    steps_r;
  logic             eq_r, gt_r, lt_r;
  logic             load, step;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [DIGIT-1:0] da, db;

  assign sh_a = ra >> (DIGIT * int'(idx));
  assign sh_b = rb >> (DIGIT * int'(idx));
  assign da   = sh_a[DIGIT-1:0];
  assign db   = sh_b[DIGIT-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          load      = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (da != db || idx == '0) state_nxt = DONE;
        end
      end
      DONE: begin
        // flush wins over a simultaneous handshake; either way we return to IDLE
        if (flush || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra      <= '0;
      rb      <= '0;
      idx     <= '0;
      steps_r <= '0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
    end else if (load) begin
      ra      <= is_signed ? (a ^ MSB_MASK) : a;
      rb      <= is_signed ? (b ^ MSB_MASK) : b;
      idx     <= IW'(NDIG - 1);
      steps_r <= '0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
    end else if (step) begin
      steps_r <= steps_r + SW'(1);
      if (da > db)        gt_r <= 1'b1;
      else if (da < db)   lt_r <= 1'b1;
      else if (idx == '0) eq_r <= 1'b1;
      else                idx  <= idx - IW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign eq        = eq_r & out_valid;
  assign gt        = gt_r & out_valid;
  assign lt        = lt_r & out_valid;
  assign steps     = steps_r;

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// tb/tb_magnitude_comparator_seq.sv - scoreboard bench for magnitude_comparator_seq (WIDTH=8, DIGIT=2)
module tb_magnitude_comparator_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, is_signed, flush, out_valid, out_ready;
  logic [7:0] a, b;
  logic       eq, gt, lt;
  logic [2:0] steps;

  int checks   = 0;
  int failures = 0;
  logic [5:0] sb[$];

  magnitude_comparator_seq #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .gt(gt), .lt(lt), .steps(steps)
  );

  always #5 clk = ~clk;

  // {eq, gt, lt, steps}: outcome from a plain integer compare, steps from the first differing digit
  function automatic logic [5:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] d;
    logic [2:0] st;
    logic       found;
    logic       e, g, l;
    d = x ^ y;
    st = 3'd4;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && d[i*2 +: 2] != 2'b00) begin
        st = 3'(4 - i);
        found = 1'b1;
      end
    end
    if (s) begin
      g = $signed(x) > $signed(y);
      l = $signed(x) < $signed(y);
    end else begin
      g = x > y;
      l = x < y;
    end
    e = (x == y);
    return {e, g, l, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, eq, gt, lt, steps} !== {1'b1, 1'b0, 3'b000, 3'd0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b ov=%b egl=%b%b%b st=%0d want rdy=1 ov=0 egl=000 st=0",
               in_ready, out_valid, eq, gt, lt, steps);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic is, input int hold);
    logic [5:0] exp;
    int cyc;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL op_ready_before got %b want 1", in_ready);
    end
    a = ia; b = ib; is_signed = is; in_valid = 1'b1;
    sb.push_back(model(ia, ib, is));
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL busy_ready cyc=%0d got %b want 0", cyc, in_ready);
      end
      tick();
      cyc++;
    end
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL op_timeout a=%h b=%h got no out_valid want result", ia, ib);
      return;
    end
    checks++;
    if (cyc !== int'(exp[2:0])) begin
      failures++;
      $display("FAIL latency a=%h b=%h s=%b got %0d want %0d", ia, ib, is, cyc, exp[2:0]);
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({out_valid, in_ready, eq, gt, lt, steps} !== {2'b10, exp}) begin
        failures++;
        $display("FAIL result a=%h b=%h s=%b hold=%0d got ov=%b rdy=%b egl=%b%b%b st=%0d want egl=%b st=%0d",
                 ia, ib, is, h, out_valid, in_ready, eq, gt, lt, steps, exp[5:3], exp[2:0]);
      end
      if (h < hold) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, eq, gt, lt} !== 5'b01000) begin
      failures++;
      $display("FAIL after_handshake got ov=%b rdy=%b egl=%b%b%b want ov=0 rdy=1 egl=000",
               out_valid, in_ready, eq, gt, lt);
    end
  endtask

  task automatic test_directed();
    do_op(8'hC3, 8'h43, 1'b0, 0);
    do_op(8'hC3, 8'h43, 1'b1, 0);
    do_op(8'h5A, 8'h5A, 1'b0, 0);
    do_op(8'h5A, 8'h5A, 1'b1, 0);
    do_op(8'h12, 8'h13, 1'b0, 0);
    do_op(8'h80, 8'h7F, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    do_op(8'hC3, 8'h43, 1'b0, 3);
    do_op(8'h12, 8'h13, 1'b0, 3);
  endtask

  task automatic test_flush();
    a = 8'hFF; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL flush_cmp got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_pulse cyc=%0d got ov=%b want 0", i, out_valid);
      end
      tick();
    end
    do_op(8'h01, 8'h00, 1'b0, 0);
    // flush in IDLE blocks capture on that edge
    a = 8'h01; b = 8'h02; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL flush_idle got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
    // flush and out_ready together in DONE: result discarded
    a = 8'h80; b = 8'h00; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, gt, steps} !== {2'b11, 3'd1}) begin
      failures++;
      $display("FAIL flush_done_pre got ov=%b gt=%b st=%0d want ov=1 gt=1 st=1", out_valid, gt, steps);
    end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, gt} !== 3'b010) begin
      failures++;
      $display("FAIL flush_done got ov=%b rdy=%b gt=%b want ov=0 rdy=1 gt=0", out_valid, in_ready, gt);
    end
  endtask

  task automatic test_async_reset();
    a = 8'hFF; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, eq, gt, lt, steps} !== {1'b1, 1'b0, 3'b000, 3'd0}) begin
      failures++;
      $display("FAIL async_reset got rdy=%b ov=%b egl=%b%b%b st=%0d want rdy=1 ov=0 egl=000 st=0",
               in_ready, out_valid, eq, gt, lt, steps);
    end
    #1 rst = 1'b0;
    tick();
    do_op(8'h34, 8'h35, 1'b0, 1);
    do_op(8'hFE, 8'h01, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/magnitude_comparator_seq.md
MAGNITUDE_COMPARATOR_SEQ -- requirements
Module: magnitude_comparator_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..64.
REQ-002 Parameter DIGIT, default 2: bits compared per cycle; legal range 1..WIDTH; WIDTH mod DIGIT SHALL equal 0; NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
REQ-010 flush  input  1  synchronous abort of any comparison in progress.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 eq, gt, lt  output  1 each  A==B, A>B, A<B; exactly one high while out_valid=1.
REQ-014 steps  output  clog2(NDIG)+1  number of digit compares used for the current result.

Function
REQ-015 FSM SHALL have states IDLE, CMP, DONE.
REQ-016 IDLE: in_ready=1; in_valid=1 at a clock edge captures a, b, is_signed; digit index set to NDIG-1; steps cleared; next state CMP.
REQ-017 Signed mode: at capture, MSB of both operands SHALL be inverted; all later compares are unsigned on the stored values.
REQ-018 CMP: each cycle compares stored digit [idx*DIGIT +: DIGIT] of A vs B, MSB digit first; steps increments by 1 per compare.
REQ-019 CMP, digits differ: gt or lt set accordingly, next state DONE (early termination).
REQ-020 CMP, digits equal and idx=0: eq set, next state DONE; digits equal and idx>0: idx decrements, stay in CMP.
REQ-021 Latency: out_valid SHALL rise k edges after the accepting edge, k = steps = 1..NDIG.
REQ-022 DONE: out_valid=1; eq/gt/lt/steps held stable until out_valid&out_ready at an edge, then next state IDLE.
REQ-023 in_ready SHALL be 0 in CMP and DONE; no new operand accepted until the IDLE cycle after the handshake.
REQ-024 Outside DONE, out_valid=0, and eq/gt/lt SHALL read 0.
REQ-025 flush=1 in CMP or DONE: next state IDLE, result discarded, no out_valid pulse; flush in IDLE has no effect, and in_valid is ignored on that edge.
REQ-026 flush and out_ready both high in DONE: flush takes priority; the result counts as discarded.
REQ-027 Operand changes on a/b/is_signed after capture SHALL NOT affect the result in progress.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, eq=gt=lt=0, steps=0, idx=0, and clear operand registers, regardless of clk.
REQ-029 Reset asserted mid-CMP or in DONE SHALL abort the operation; after deassertion, the first accepted pair is processed normally.

Verification (WIDTH=8, DIGIT=2)
REQ-030 Unsigned a=0xC3, b=0x43 -> gt=1, steps=1, out_valid 1 edge after acceptance.
REQ-031 Signed a=0xC3 (-61), b=0x43 (+67) -> lt=1, steps=1; a=b=0x5A either mode -> eq=1, steps=4.
REQ-032 Unsigned a=0x12, b=0x13 -> lt=1, steps=4; in_ready=0 throughout, and a/b changed during CMP with no effect on the result.
REQ-033 Backpressure: out_ready held low 3 cycles in DONE -> out_valid, gt/lt/eq, steps stable; handshake on cycle 4, then in_ready=1 on the next cycle.
REQ-034 flush during CMP of a=b=0xFF (after 2 steps) -> IDLE, no out_valid; next pair 0x01 vs 0x00 -> gt, steps=4.
REQ-035 rst pulsed asynchronously between edges mid-CMP -> all outputs at reset values before the next edge; subsequent compare correct.
